// File: rtl/latch_rf_pkg.sv
// rtl/latch_rf_pkg.sv - shared types and constants for the latch register-file reader
package latch_rf_pkg;

    localparam int RSP_DEPTH      = 2;
    localparam int RSP_DATA_WIDTH = 32;

    typedef struct packed {
        logic [RSP_DATA_WIDTH-1:0] data;
        logic                      err;
    } rsp_entry_t;

    function automatic int addr_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/latch_rf_rsp_fifo.sv
// rtl/latch_rf_rsp_fifo.sv - 2-entry valid/ready response FIFO with flush
module latch_rf_rsp_fifo
    import latch_rf_pkg::*;
#(
    parameter int WIDTH = $bits(rsp_entry_t)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    logic [WIDTH-1:0] mem [RSP_DEPTH];
    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push;
    logic             pop;

    assign pop_valid  = (count != 2'd0);
    assign pop        = pop_valid & pop_ready;
    // A full buffer still takes a push when the head leaves in the same cycle.
    assign push_ready = ~flush & ((count < 2'(RSP_DEPTH)) | pop);
    assign push       = push_valid & push_ready;
    assign pop_data   = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/latch_rf_reader.sv
// rtl/latch_rf_reader.sv - read port for a latch register bank; LATCH_RF_READ_BYPASS_EN forwards same-cycle writes
module latch_rf_reader
    import latch_rf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = addr_width(NUM_REGS),
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] rf_rdata_i,
    input  logic                           wr_en_i,
    input  logic [ADDR_WIDTH-1:0]          wr_addr_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    input  logic                           flush_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [ADDR_WIDTH-1:0]          req_addr_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [DATA_WIDTH-1:0]          rsp_data_o,
    output logic                           rsp_err_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  err;
    } entry_t;

    localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH+1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0] words [NUM_REGS];
    logic                  ready_en;
    logic                  fifo_ready;
    logic                  addr_oob;
    logic                  addr_zero;
    entry_t                sel;
    entry_t                head;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
        assign words[i] = rf_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Holds the request side closed until the first edge after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign addr_oob  = ({1'b0, req_addr_i} >= NUM_REGS_W);
    assign addr_zero = (ZERO_REG != 0) && (req_addr_i == '0);

    always_comb begin
        sel = '0;
        if (addr_oob) begin
            sel.err = 1'b1;
        end else if (!addr_zero) begin
            sel.data = words[req_addr_i];
`ifdef LATCH_RF_READ_BYPASS_EN
            // The cell only shows this write after the edge, so forward it directly.
            if (wr_en_i && (wr_addr_i == req_addr_i)) begin
                sel.data = wr_data_i;
            end
`endif
        end
    end

`ifndef LATCH_RF_READ_BYPASS_EN
    logic unused_wr;
    assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

    latch_rf_rsp_fifo #(
        .WIDTH ($bits(entry_t))
    ) u_rsp_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush      (flush_i),
        .push_valid (req_valid_i & ready_en),
        .push_ready (fifo_ready),
        .push_data  (sel),
        .pop_valid  (rsp_valid_o),
        .pop_ready  (rsp_ready_i),
        .pop_data   (head)
    );

    assign req_ready_o = fifo_ready & ready_en;
    assign rsp_data_o  = head.data;
    assign rsp_err_o   = head.err;

endmodule
